// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO arbitration controller.
package fifo_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // First set bit of valid at or after ptr, wrapping at n (n <= 32); ptr if none set.
    function automatic int unsigned rr_pick(input logic [31:0] valid,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned idx;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < 32; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && valid[idx[4:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: prefetches from a FIFO with 1-cycle registered dout into a
// 2-entry output/skid stage presented as a valid/ready stream.
module fifo_rd_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_rd_en_o,
    input  logic [WIDTH-1:0] fifo_dout_i,
    input  logic             fifo_empty_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic [1:0]       occ_q;
    logic             inflight_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] skid_q;
    logic             pop;
    logic [2:0]       level;

    assign pop          = out_valid_o & out_ready_i;
    // Entries that will be held once this cycle's pop and the pending read settle.
    assign level        = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en_o = ~rst & ~fifo_empty_i & (level < 3'd2);
    assign out_valid_o  = (occ_q != 2'd0);
    assign out_data_o   = out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            inflight_q <= fifo_rd_en_o;
            case ({pop, inflight_q})
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        out_q  <= skid_q;
                        skid_q <= fifo_dout_i;
                    end else begin
                        out_q  <= fifo_dout_i;
                    end
                end
                2'b10: begin
                    occ_q <= occ_q - 2'd1;
                    out_q <= skid_q;
                end
                2'b01: begin
                    occ_q <= occ_q + 2'd1;
                    if (occ_q == 2'd0) out_q  <= fifo_dout_i;
                    else               skid_q <= fifo_dout_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Shares one FIFO between NREQ producers: round-robin bounded-burst write arbiter,
// read side drained through fifo_rd_stream as a valid/ready stream.
module fifo_arb_ctrl
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [WIDTH-1:0]        fifo_din,
    output logic                    fifo_wr_en,
    input  logic                    fifo_full,
    output logic                    fifo_rd_en,
    input  logic [WIDTH-1:0]        fifo_dout,
    input  logic                    fifo_empty,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    arb_state_t     state_q;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] rr_q;
    logic [IDW-1:0] rr_d;
    logic [CW-1:0]  count_q;
    logic           own_valid;
    logic           accept;

    // Beats are suppressed during the reset cycle itself, not just after it.
    assign own_valid  = req_valid[owner_q];
    assign accept     = ~rst & (state_q == GRANT) & own_valid & ~fifo_full;
    assign fifo_wr_en = accept;
    assign fifo_din   = req_data[owner_q*WIDTH +: WIDTH];
    assign grant_id   = owner_q;
    assign rr_d       = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        req_ready = '0;
        if (!rst && state_q == GRANT) req_ready[owner_q] = ~fifo_full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        owner_q <= IDW'(rr_pick(32'(req_valid), 32'(rr_q), NREQ));
                        count_q <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) count_q <= count_q + 1'b1;
                    if (!own_valid || (accept && count_q == CW'(MAX_BURST - 1))) begin
                        rr_q    <= rr_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fifo_rd_stream #(
        .WIDTH(WIDTH)
    ) u_rd_stream (
        .clk         (clk),
        .rst         (rst),
        .fifo_rd_en_o(fifo_rd_en),
        .fifo_dout_i (fifo_dout),
        .fifo_empty_i(fifo_empty),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready)
    );

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Bench for fifo_arb_ctrl: behavioural FIFO, transaction-level arbiter model and
// an in-order scoreboard on the output stream.
module tb_fifo_arb_ctrl;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int FDEPTH    = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [1:0]            grant_id;
    logic [WIDTH-1:0]      fifo_din;
    logic                  fifo_wr_en;
    logic                  fifo_full;
    logic                  fifo_rd_en;
    logic [WIDTH-1:0]      fifo_dout;
    logic                  fifo_empty;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_ready;

    always #5 clk = ~clk;

    fifo_arb_ctrl #(
        .NREQ(NREQ),
        .WIDTH(WIDTH),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .fifo_din  (fifo_din),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full (fifo_full),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    // Standard FIFO, 8 slots, one kept free so it holds at most 7 words.
    logic [WIDTH-1:0] fmem [FDEPTH];
    int fcnt = 0;
    int fwp  = 0;
    int frp  = 0;

    assign fifo_empty = (fcnt == 0);
    assign fifo_full  = (fcnt == FDEPTH - 1);

    always @(posedge clk) begin
        if (rst) begin
            fcnt      <= 0;
            fwp       <= 0;
            frp       <= 0;
            fifo_dout <= '0;
        end else begin
            if (fifo_wr_en && !fifo_full) begin
                fmem[fwp] <= fifo_din;
                fwp       <= (fwp + 1) % FDEPTH;
            end
            if (fifo_rd_en && !fifo_empty) begin
                fifo_dout <= fmem[frp];
                frp       <= (frp + 1) % FDEPTH;
            end
            fcnt <= fcnt + ((fifo_wr_en && !fifo_full) ? 1 : 0)
                         - ((fifo_rd_en && !fifo_empty) ? 1 : 0);
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [WIDTH-1:0] base [NREQ];
    logic [WIDTH-1:0] pseq [NREQ];

    // Arbiter model state
    bit m_granted;
    int m_owner, m_rr, m_beats, m_gid;

    logic [WIDTH-1:0] sb[$];
    int               wq[$];

    int               acc_owner;
    bit               stall_prev;
    logic [WIDTH-1:0] data_prev;
    int               pops;
    bit               lat_chk;

    int exp_t1_owner [10] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0};
    int exp_t1_cyc   [10] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 50)
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = base[i] + pseq[i];
    endtask

    // One clock: check at negedge, advance the model, then step inputs after posedge.
    task automatic step();
        logic [NREQ-1:0]  exp_ready;
        logic [WIDTH-1:0] exp_d;
        bit               acc;
        int               wc, idx;
        @(negedge clk);
        exp_ready = '0;
        if (!rst && m_granted && !fifo_full) exp_ready[m_owner] = 1'b1;
        acc = !rst && m_granted && req_valid[m_owner] && !fifo_full;
        chk("req_ready", req_ready, exp_ready);
        chk("wr_en", fifo_wr_en, acc);
        chk("grant_id", grant_id, m_gid);
        chk("rd_when_empty", fifo_rd_en & fifo_empty, 0);
        acc_owner = -1;
        for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) acc_owner = i;
        if (acc) begin
            chk("din", fifo_din, req_data[m_owner*WIDTH +: WIDTH]);
            sb.push_back(req_data[m_owner*WIDTH +: WIDTH]);
            wq.push_back(cyc);
        end
        if (rst) begin
            chk("rd_en_in_rst", fifo_rd_en, 0);
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, data_prev);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("pop_without_data", sb.size(), 1);
                end else begin
                    exp_d = sb.pop_front();
                    wc    = wq.pop_front();
                    chk("out_data", out_data, exp_d);
                    if (lat_chk) chk("latency", cyc - wc, 3);
                    pops++;
                end
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
        end
        if (rst) begin
            m_granted = 1'b0;
            m_rr      = 0;
            m_beats   = 0;
            m_gid     = 0;
            sb.delete();
            wq.delete();
        end else if (!m_granted) begin
            if (req_valid != '0) begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    idx = (m_rr + k) % NREQ;
                    if (req_valid[idx]) m_owner = idx;
                end
                m_gid     = m_owner;
                m_granted = 1'b1;
                m_beats   = 0;
            end
        end else begin
            if (acc) m_beats++;
            if (!req_valid[m_owner] || m_beats == MAX_BURST) begin
                m_granted = 1'b0;
                m_rr      = (m_owner + 1) % NREQ;
            end
        end
        idx = m_owner;
        cyc++;
        @(posedge clk);
        #1;
        if (acc) pseq[idx] = pseq[idx] + 1'b1;
        drive_data();
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic rand_valid();
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(1) == 1) begin
                req_valid[i] = 1'b1;
            end
        end
    endtask

    task automatic drain(input string tag);
        req_valid = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 60 && sb.size() != 0; k++) step();
        step();
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        int c0, nb, npop, nacc;
        bit found;
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        lat_chk   = 1'b0;
        pops      = 0;
        for (int i = 0; i < NREQ; i++) begin
            base[i] = WIDTH'(i << 6);
            pseq[i] = '0;
        end
        drive_data();

        reset_dut();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_grant_id", grant_id, 0);

        // Two held producers alternate in bursts of MAX_BURST
        req_valid = 4'b0101;
        out_ready = 1'b1;
        c0 = cyc;
        nb = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (acc_owner >= 0 && nb < 10) begin
                chk("t1_owner", acc_owner, exp_t1_owner[nb]);
                chk("t1_cycle", cyc - 1 - c0, exp_t1_cyc[nb]);
                nb++;
            end
        end
        chk("t1_beats", nb, 10);
        drain("t1_drain");

        // Owner 1 drops valid after two beats; owner 2 follows
        reset_dut();
        req_valid = 4'b0110;
        out_ready = 1'b1;
        c0 = cyc;
        nb = 0;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            step();
            if (acc_owner == 1) begin
                nb++;
                if (nb == 2) req_valid[1] = 1'b0;
            end else if (acc_owner >= 0) begin
                chk("t2_next_owner", acc_owner, 2);
                chk("t2_next_cycle", cyc - 1 - c0, 5);
                found = 1'b1;
            end
        end
        chk("t2_found", found, 1);
        chk("t2_owner1_beats", nb, 2);
        drain("t2_drain");

        // Fill FIFO and output stage with the sink stalled
        reset_dut();
        req_valid = 4'b0011;
        out_ready = 1'b0;
        nacc = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (acc_owner >= 0) nacc++;
        end
        chk("t3_accepted", nacc, 9);
        chk("t3_ready_stalled", req_ready, 0);
        chk("t3_owner_kept", grant_id, 0);
        req_valid = '0;
        out_ready = 1'b1;
        npop = pops;
        for (int k = 0; k < 9; k++) step();
        chk("t3_drain_rate", pops - npop, 9);
        drain("t3_drain");

        // Sequential stream from producer 2
        reset_dut();
        base[2]   = '0;
        pseq[2]   = '0;
        drive_data();
        req_valid = 4'b0100;
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        npop = pops;
        for (int k = 0; k < 60 && pops - npop < 20; k++) begin
            step();
            if (pseq[2] == 8'd20) req_valid = '0;
        end
        lat_chk = 1'b0;
        chk("t4_pops", pops - npop, 20);
        chk("t4_last_seq", pseq[2], 20);
        base[2] = WIDTH'(2 << 6);
        drive_data();

        // Random producers with a toggling sink
        reset_dut();
        out_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            rand_valid();
            out_ready = ~out_ready;
            step();
        end
        drain("t5_drain");

        // Reset in the middle of a stalled burst
        reset_dut();
        out_ready = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) step();
        chk("t6_pre_valid", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_req_ready", req_ready, 0);
        chk("t6_wr_en", fifo_wr_en, 0);
        chk("t6_rd_en", fifo_rd_en, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_grant_id", grant_id, 0);
        for (int k = 0; k < 150; k++) begin
            rand_valid();
            out_ready = ($urandom_range(3) != 0);
            step();
        end
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
